logic_op_sequencer: RTL and testbench

//  Registered command front-end and result back-end for the 8-bit XOR/NOR/NAND logic unit.

---
 rtl/logic_op_sequencer.sv | 130 +++++++++++++
 tb/tb_logic_op_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_sequencer.sv
// Command/response sequencer for the external 8-bit XOR/NOR/NAND logic unit.
// Registers operands and select bits toward the unit, then captures its result one cycle later.
module logic_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_op,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic              unit_s1,
    output logic              unit_s0,
    input  logic [DATA_W-1:0] unit_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [1:0]        op_reg, op_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              ready_comb;
    logic              cmd_accept;
    logic              op_illegal;
    logic [DATA_W-1:0] result_masked;

    // Select 11 has no defined unit function, so its result is forced to zero.
    assign op_illegal = &op_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : gen_mask
            assign result_masked[gi] = unit_out[gi] & ~op_illegal;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        ready_comb = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_comb = 1'b1;
            end
            EXEC: begin
                state_next = RESP;
                data_next  = result_masked;
                err_next   = op_illegal;
            end
            RESP: begin
                if (rsp_ready) begin
                    ready_comb = 1'b1;
                    state_next = IDLE;
                    if (!err_reg && (cnt_reg != {CNT_W{1'b1}})) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new command can be taken from IDLE or in the same cycle a response retires.
        if (cmd_accept) begin
            state_next = EXEC;
            a_next     = cmd_a;
            b_next     = cmd_b;
            op_next    = cmd_op;
        end
    end

    assign cmd_accept = cmd_valid && ready_comb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Gated by rst_n so no command is offered while the block is held in reset.
    assign cmd_ready = rst_n && ready_comb;
    assign unit_a    = a_reg;
    assign unit_b    = b_reg;
    assign unit_s1   = op_reg[1];
    assign unit_s0   = op_reg[0];
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = data_reg;
    assign rsp_err   = err_reg;
    assign op_count  = cnt_reg;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Scoreboard bench for logic_op_sequencer with a behavioural logic unit beside each instance.
// A second instance with a 2-bit counter exercises op_count saturation.
module tb_logic_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [1:0] cmd_op = '0;
    logic       rsp_ready = 1'b1;

    logic        cmd_ready, unit_s1, unit_s0, rsp_valid, rsp_err;
    logic [7:0]  unit_a, unit_b, unit_out, rsp_data;
    logic [15:0] op_count;

    logic        cmd_ready2, unit_s1_2, unit_s0_2, rsp_valid2, rsp_err2;
    logic [7:0]  unit_a2, unit_b2, unit_out2, rsp_data2;
    logic [1:0]  op_count2;

    always #5 clk = ~clk;

    logic_op_sequencer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .unit_a(unit_a), .unit_b(unit_b), .unit_s1(unit_s1), .unit_s0(unit_s0),
        .unit_out(unit_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
    );

    logic_op_sequencer #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .unit_a(unit_a2), .unit_b(unit_b2), .unit_s1(unit_s1_2), .unit_s0(unit_s0_2),
        .unit_out(unit_out2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .rsp_err(rsp_err2), .op_count(op_count2)
    );

    // External logic unit; select 11 returns a junk pattern that must never reach rsp_data.
    function automatic logic [7:0] unit_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
        case (s)
            2'b00:   return a ^ b;
            2'b01:   return ~(a | b);
            2'b10:   return ~(a & b);
            default: return 8'hA5;
        endcase
    endfunction

    assign unit_out  = unit_fn(unit_a, unit_b, {unit_s1, unit_s0});
    assign unit_out2 = unit_fn(unit_a2, unit_b2, {unit_s1_2, unit_s0_2});

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         t;
    } exp_t;

    exp_t        sb[$];
    int unsigned mcnt = 0;
    int unsigned mcnt2 = 0;
    int          ncyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;

    // Monitor: samples on the falling edge, i.e. just before the edge that performs a handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mcnt  = 0;
            mcnt2 = 0;
        end else begin
            if (rsp_valid && (!prev_valid || prev_hs)) begin
                if (sb.size() > 0) chk("latency", ncyc - sb[0].t, 2);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("rsp_data", rsp_data, x.d);
                    chk("rsp_err", rsp_err, x.e);
                    chk("rsp_data_w2", rsp_data2, x.d);
                    chk("op_count", op_count, mcnt);
                    chk("op_count_w2", op_count2, mcnt2);
                    $display("rsp data=%02h err=%0d count=%0d count2=%0d", rsp_data, rsp_err,
                             op_count, op_count2);
                    if (!x.e) begin
                        if (mcnt < 32'd65535) mcnt++;
                        if (mcnt2 < 32'd3) mcnt2++;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t x;
                case (cmd_op)
                    2'b00:   begin x.d = cmd_a ^ cmd_b;    x.e = 1'b0; end
                    2'b01:   begin x.d = ~(cmd_a | cmd_b); x.e = 1'b0; end
                    2'b10:   begin x.d = ~(cmd_a & cmd_b); x.e = 1'b0; end
                    default: begin x.d = 8'h00;            x.e = 1'b1; end
                endcase
                x.t = ncyc;
                sb.push_back(x);
                $display("cmd a=%02h b=%02h op=%0d", cmd_a, cmd_b, cmd_op);
            end
        end
        prev_valid = rsp_valid;
        prev_hs    = rsp_valid && rsp_ready;
        ncyc++;
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int n;
        n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("send_timeout", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 50) chk("drain_timeout", rsp_valid, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_unit_a"}, unit_a, 8'h00);
        chk({tag, "_unit_b"}, unit_b, 8'h00);
        chk({tag, "_sel"}, {unit_s1, unit_s0}, 2'b00);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_data}, 10'h000);
        chk({tag, "_count"}, op_count, 16'h0000);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    endtask

    logic [7:0] held;
    logic [1:0] cnt2_tab [5];

    initial begin
        cnt2_tab[0] = 2'd1; cnt2_tab[1] = 2'd2; cnt2_tab[2] = 2'd3;
        cnt2_tab[3] = 2'd3; cnt2_tab[4] = 2'd3;

        // Reset state
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        #1 chk("ready_after_reset", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Test 1
        send(8'h77, 8'h0B, 2'b00);
        send(8'h77, 8'h0B, 2'b01);
        send(8'h77, 8'h0B, 2'b10);
        wait_idle();
        chk("t1_count", op_count, 16'd3);

        // Test 2
        send(8'h69, 8'hA5, 2'b00);
        send(8'h69, 8'hA5, 2'b01);
        send(8'h69, 8'hA5, 2'b10);
        wait_idle();
        chk("t2_count", op_count, 16'd6);

        // Test 3: illegal op
        send(8'hFF, 8'h00, 2'b11);
        wait_idle();
        chk("t3_count", op_count, 16'd6);

        // Test 4: backpressure, then retire and accept on the same edge
        rsp_ready = 1'b0;
        send(8'h12, 8'h34, 2'b00);
        for (int i = 0; i < 10 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("t4_valid", rsp_valid, 1'b1);
        held = rsp_data;
        cmd_a = 8'h5A; cmd_b = 8'h0F; cmd_op = 2'b01; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_stable", rsp_data, 8'h26);
            chk("t4_valid_hold", rsp_valid, 1'b1);
            chk("t4_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        #1 chk("t4_ready_comb", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("t4_same_edge", {unit_a, unit_b, unit_s1, unit_s0}, {8'h5A, 8'h0F, 2'b01});
        chk("t4_valid_drop", rsp_valid, 1'b0);
        chk("t4_held_first", held, 8'h26);
        wait_idle();
        chk("t4_count", op_count, 16'd8);

        // Test 5: reset during EXEC
        send(8'hC3, 8'h3C, 2'b10);
        rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("t5_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_no_rsp", rsp_valid, 1'b0);
        end

        // Test 6: counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            send(8'(i * 17), 8'h5C, 2'(i % 3));
            wait_idle();
            chk("t6_count2", op_count2, cnt2_tab[i]);
        end
        chk("t6_count16", op_count, 16'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
